// File: rtl/decode_pkg.sv
// Shared decode definitions: opcodes, control-word layout and the control typedef.
// The control word travels with each instruction from decode into execute.
package decode_pkg;

  localparam logic [5:0] OP_NOP = 6'h00;
  localparam logic [5:0] OP_ADD = 6'h01;
  localparam logic [5:0] OP_SUB = 6'h02;
  localparam logic [5:0] OP_AND = 6'h03;
  localparam logic [5:0] OP_OR  = 6'h04;
  localparam logic [5:0] OP_SLL = 6'h06;
  localparam logic [5:0] OP_SRL = 6'h07;
  localparam logic [5:0] OP_LDD = 6'h20;
  localparam logic [5:0] OP_STD = 6'h21;

  // MEM = {memRead, memWrite, memAddr[1:0], memData}
  localparam int MEM_RD_BIT   = 4;
  localparam int MEM_WR_BIT   = 3;
  localparam int MEM_ADDR_LSB = 1;
  localparam int MEM_DATA_BIT = 0;
  // EX = {ALUop[3:0], ALUen, shamtSel}
  localparam int EX_ALUOP_LSB = 2;
  localparam int EX_ALUEN_BIT = 1;
  localparam int EX_SHSEL_BIT = 0;
  // WB = {regWrite, WBsel[1:0]}
  localparam int WB_REGW_BIT  = 2;
  localparam int WB_SEL_LSB   = 0;

  localparam logic [1:0] MEM_ADDR_BASE = 2'b01;
  localparam logic [1:0] WB_ALU        = 2'b00;
  localparam logic [1:0] WB_MEM        = 2'b01;

  typedef enum logic [3:0] {
    ALU_NONE = 4'd0,
    ALU_ADD  = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_AND  = 4'd3,
    ALU_OR   = 4'd4,
    ALU_SLL  = 4'd6,
    ALU_SRL  = 4'd7
  } alu_op_e;

  typedef struct packed {
    logic [4:0] mem;
    logic [5:0] ex;
    logic [2:0] wb;
  } ctrl_t;

  // Register-to-register ALU instruction writing its result back from the ALU.
  function automatic ctrl_t alu_ctrl(alu_op_e op, logic shsel);
    ctrl_t c;
    c = '0;
    c.ex[EX_ALUOP_LSB +: 4]  = op;
    c.ex[EX_ALUEN_BIT]       = 1'b1;
    c.ex[EX_SHSEL_BIT]       = shsel;
    c.wb[WB_REGW_BIT]        = 1'b1;
    c.wb[WB_SEL_LSB +: 2]    = WB_ALU;
    return c;
  endfunction

endpackage

// File: rtl/decode_stage_hz_ctrl.sv
// Combinational opcode to {MEM, EX, WB} control table; unknown opcodes behave as NOP.
module decode_ctrl
  import decode_pkg::*;
#(
  parameter int OPW = 6
) (
  input  logic [OPW-1:0] i_opcode,
  output ctrl_t          o_ctrl
);

  always_comb begin
    // NOTE: the default assignment up front keeps every path driven, so no latch is inferred.
    o_ctrl = '0;
    case (i_opcode)
      OPW'(OP_NOP): o_ctrl = '0;
      OPW'(OP_ADD): o_ctrl = alu_ctrl(ALU_ADD, 1'b0);
      OPW'(OP_SUB): o_ctrl = alu_ctrl(ALU_SUB, 1'b0);
      OPW'(OP_AND): o_ctrl = alu_ctrl(ALU_AND, 1'b0);
      OPW'(OP_OR):  o_ctrl = alu_ctrl(ALU_OR,  1'b0);
      OPW'(OP_SLL): o_ctrl = alu_ctrl(ALU_SLL, 1'b1);
      OPW'(OP_SRL): o_ctrl = alu_ctrl(ALU_SRL, 1'b1);
      OPW'(OP_LDD): begin
        o_ctrl = alu_ctrl(ALU_ADD, 1'b0);
        o_ctrl.mem[MEM_RD_BIT]          = 1'b1;
        o_ctrl.mem[MEM_ADDR_LSB +: 2]   = MEM_ADDR_BASE;
        o_ctrl.wb[WB_SEL_LSB +: 2]      = WB_MEM;
      end
      OPW'(OP_STD): begin
        o_ctrl = alu_ctrl(ALU_ADD, 1'b0);
        o_ctrl.mem[MEM_WR_BIT]          = 1'b1;
        o_ctrl.mem[MEM_ADDR_LSB +: 2]   = MEM_ADDR_BASE;
        o_ctrl.mem[MEM_DATA_BIT]        = 1'b1;
        o_ctrl.wb[WB_REGW_BIT]          = 1'b0;
      end
      default:      o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage_hz.sv
// Decode stage: F/D and D/E pipeline registers, register file with WB bypass,
// load-use bubble insertion and a saturating bubble counter.
module decode_stage_hz
  import decode_pkg::*;
#(
  parameter int W   = 16,
  parameter int N   = 3,
  parameter int OPW = 6,
  parameter int SHW = 4,
  parameter int CW  = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           fd_valid_i,
  input  logic [2*W-1:0] fd_data_i,
  output logic           fd_ready_o,
  input  logic           flush_i,
  input  logic           wb_we_i,
  input  logic [N-1:0]   wb_addr_i,
  input  logic [W-1:0]   wb_data_i,
  input  logic           de_ready_i,
  output logic           de_valid_o,
  output logic [4:0]     de_mem_o,
  output logic [5:0]     de_ex_o,
  output logic [2:0]     de_wb_o,
  output logic [W-1:0]   de_rsrc_o,
  output logic [W-1:0]   de_rdst_o,
  output logic [SHW-1:0] de_shamt_o,
  output logic [W-1:0]   de_imm_o,
  output logic [N-1:0]   de_src_o,
  output logic [N-1:0]   de_dst_o,
  output logic [CW-1:0]  stall_cnt_o
);

  typedef struct packed {
    ctrl_t          ctrl;
    logic [W-1:0]   rsrc;
    logic [W-1:0]   rdst;
    logic [SHW-1:0] shamt;
    logic [W-1:0]   imm;
    logic [N-1:0]   src;
    logic [N-1:0]   dst;
  } de_t;

  logic           r_fd_v;
  logic [2*W-1:0] r_fd_data;
  logic [W-1:0]   r_rf [2**N];
  logic           r_de_v;
  de_t            r_de;
  logic [CW-1:0]  r_stall_cnt;

  logic [W-1:0]   w_instr;
  logic [OPW-1:0] w_op;
  logic [N-1:0]   w_src;
  logic [N-1:0]   w_dst;
  logic [SHW-1:0] w_shamt;
  logic [W-1:0]   w_rd_src;
  logic [W-1:0]   w_rd_dst;
  ctrl_t          w_ctrl;
  de_t            w_de_load;
  logic           w_load_use;
  logic           w_de_free;
  logic           w_advance;

  // instr = {opcode, src, dst, shamt}, MSB first
  assign w_instr = r_fd_data[2*W-1:W];
  assign w_op    = w_instr[W-1 -: OPW];
  assign w_src   = w_instr[SHW+N +: N];
  assign w_dst   = w_instr[SHW +: N];
  assign w_shamt = w_instr[SHW-1:0];

  decode_ctrl #(.OPW(OPW)) u_ctrl (
    .i_opcode (w_op),
    .o_ctrl   (w_ctrl)
  );

  // A write-back to the register being read is forwarded so decode never sees a stale value.
  assign w_rd_src = (wb_we_i && (wb_addr_i == w_src)) ? wb_data_i : r_rf[w_src];
  assign w_rd_dst = (wb_we_i && (wb_addr_i == w_dst)) ? wb_data_i : r_rf[w_dst];

  assign w_de_load = '{ctrl: w_ctrl, rsrc: w_rd_src, rdst: w_rd_dst, shamt: w_shamt,
                       imm: r_fd_data[W-1:0], src: w_src, dst: w_dst};

  assign w_load_use = r_fd_v && r_de_v && r_de.ctrl.mem[MEM_RD_BIT] &&
                      ((r_de.dst == w_src) || (r_de.dst == w_dst));
  assign w_de_free  = !r_de_v || de_ready_i;
  assign w_advance  = r_fd_v && w_de_free && !w_load_use;
  assign fd_ready_o = !r_fd_v || w_advance;

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst) begin
      r_fd_v    <= 1'b0;
      r_fd_data <= '0;
    end else if (flush_i) begin
      r_fd_v    <= 1'b0;
    end else if (fd_valid_i && fd_ready_o) begin
      r_fd_v    <= 1'b1;
      r_fd_data <= fd_data_i;
    end else if (w_advance) begin
      r_fd_v    <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_de_v      <= 1'b0;
      r_de        <= '0;
      r_stall_cnt <= '0;
    end else if (flush_i) begin
      r_de_v      <= 1'b0;
      r_de        <= '0;
    end else if (w_advance) begin
      r_de_v      <= 1'b1;
      r_de        <= w_de_load;
    end else if (w_de_free && w_load_use) begin
      r_de_v      <= 1'b0;
      r_de        <= '0;
      if (r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + CW'(1);
    end else if (w_de_free) begin
      r_de_v      <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: this memory is reset on purpose (entries must read 0 after reset), so it maps to flops, not a RAM macro.
    if (!rst) begin
      for (int i = 0; i < 2**N; i++) r_rf[i] <= '0;
    end else if (wb_we_i) begin
      r_rf[wb_addr_i] <= wb_data_i;
    end
  end

  assign de_valid_o  = r_de_v;
  assign de_mem_o    = r_de.ctrl.mem;
  assign de_ex_o     = r_de.ctrl.ex;
  assign de_wb_o     = r_de.ctrl.wb;
  assign de_rsrc_o   = r_de.rsrc;
  assign de_rdst_o   = r_de.rdst;
  assign de_shamt_o  = r_de.shamt;
  assign de_imm_o    = r_de.imm;
  assign de_src_o    = r_de.src;
  assign de_dst_o    = r_de.dst;
  assign stall_cnt_o = r_stall_cnt;

endmodule
